// File: rtl/frq_sweep_sequencer.sv
// -----------------------------------------------------------------------------
// frq_sweep_sequencer
//
// Purpose:
//   Drives the frequency-select input and the active-low reset of a frequency
//   divider from a small programmable table of {select, dwell} entries. Each
//   entry's select is held for 'dwell' divider output cycles. Every change of
//   select is wrapped in a clean divider reset of RST_CYCLES clk cycles, so
//   the divider never runs on a half-applied select.
//
// Ports:
//   clk          system clock, all state on the rising edge
//   reset_n      asynchronous active-low reset (table contents are kept)
//   wr_en        table write strobe, honoured only while busy=0
//   wr_addr      table entry index
//   wr_sel       select value to store
//   wr_dwell     dwell to store; 0 marks end of sequence
//   start        pulse: run the table from entry 0 (ignored while busy)
//   stop         abort; wins over every other event
//   loop_en      wrap to entry 0 after the last entry (sampled at the wrap)
//   div_clk_in   divider output, asynchronous to clk
//   f_select     registered select to the divider
//   div_reset_n  registered active-low reset to the divider
//   busy         high while a sequence is being applied
//   done         one-cycle pulse on normal completion
//   cur_idx      table entry currently applied
// -----------------------------------------------------------------------------
module frq_sweep_sequencer #(
  parameter int DEPTH      = 8,
  parameter int SEL_W      = 5,
  parameter int DWELL_W    = 8,
  parameter int RST_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [SEL_W-1:0]         wr_sel,
  input  logic [DWELL_W-1:0]       wr_dwell,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop_en,
  input  logic                     div_clk_in,
  output logic [SEL_W-1:0]         f_select,
  output logic                     div_reset_n,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH)-1:0] cur_idx
);

  localparam int AW  = $clog2(DEPTH);
  // Counter for the LOAD phase runs 0 .. RST_CYCLES-1.
  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_NEXT = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         sync_q;
  logic [RCW-1:0]     rst_cnt_q, rst_cnt_d;
  logic [DWELL_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [AW-1:0]      cur_idx_q, cur_idx_d;
  logic [SEL_W-1:0]   f_select_q, f_select_d;
  logic               div_rst_n_q, div_rst_n_d;
  logic               done_q, done_d;

  // Sequence table: plain array with combinational read. It is never
  // written while busy, so reads during a sequence see stable contents.
  logic [SEL_W-1:0]   tbl_sel_q   [DEPTH];
  logic [DWELL_W-1:0] tbl_dwell_q [DEPTH];
  logic [DEPTH-1:0]   dwell_nz;

  logic               busy_w;
  logic               edge_det;
  logic [AW-1:0]      nxt_idx;
  logic               seq_end;
  logic [DWELL_W-1:0] cur_dwell;

  assign busy_w = (state_q != S_IDLE);

  always_ff @(posedge clk) begin
    if (wr_en && !busy_w) begin
      tbl_sel_q[wr_addr]   <= wr_sel;
      tbl_dwell_q[wr_addr] <= wr_dwell;
    end
  end

  // Per-entry "not an end marker" flags.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_dwell_nz
    assign dwell_nz[gi] = |tbl_dwell_q[gi];
  end

  // sync_q[1] is the second synchronizer stage, sync_q[2] its previous value.
  assign edge_det  = sync_q[1] & ~sync_q[2];
  assign nxt_idx   = cur_idx_q + 1'b1;
  assign seq_end   = (cur_idx_q == AW'(DEPTH - 1)) || !dwell_nz[nxt_idx];
  assign cur_dwell = tbl_dwell_q[cur_idx_q];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      sync_q      <= '0;
      rst_cnt_q   <= '0;
      edge_cnt_q  <= '0;
      cur_idx_q   <= '0;
      f_select_q  <= '0;
      div_rst_n_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= {sync_q[1:0], div_clk_in};
      rst_cnt_q   <= rst_cnt_d;
      edge_cnt_q  <= edge_cnt_d;
      cur_idx_q   <= cur_idx_d;
      f_select_q  <= f_select_d;
      div_rst_n_q <= div_rst_n_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    edge_cnt_d  = edge_cnt_q;
    cur_idx_d   = cur_idx_q;
    f_select_d  = f_select_q;
    div_rst_n_d = div_rst_n_q;
    done_d      = 1'b0;

    if (stop) begin
      // Abort: select and index are deliberately left as they were.
      state_d     = S_IDLE;
      div_rst_n_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          div_rst_n_d = 1'b0;
          if (start) begin
            if (!dwell_nz[0]) begin
              done_d = 1'b1;
            end else begin
              cur_idx_d  = '0;
              f_select_d = tbl_sel_q[0];
              rst_cnt_d  = '0;
              state_d    = S_LOAD;
            end
          end
        end

        S_LOAD: begin
          if (rst_cnt_q == RCW'(RST_CYCLES - 1)) begin
            state_d     = S_RUN;
            div_rst_n_d = 1'b1;
            edge_cnt_d  = '0;
          end else begin
            rst_cnt_d = rst_cnt_q + 1'b1;
          end
        end

        S_RUN: begin
          // Compare before incrementing so a dwell of all-ones never wraps.
          if (edge_det) begin
            if (edge_cnt_q == cur_dwell - 1'b1) begin
              state_d = S_NEXT;
            end else begin
              edge_cnt_d = edge_cnt_q + 1'b1;
            end
          end
        end

        S_NEXT: begin
          if (seq_end) begin
            if (loop_en && dwell_nz[0]) begin
              cur_idx_d   = '0;
              f_select_d  = tbl_sel_q[0];
              div_rst_n_d = 1'b0;
              rst_cnt_d   = '0;
              state_d     = S_LOAD;
            end else begin
              done_d      = 1'b1;
              div_rst_n_d = 1'b0;
              state_d     = S_IDLE;
            end
          end else begin
            // New select and divider reset change on the same edge.
            cur_idx_d   = nxt_idx;
            f_select_d  = tbl_sel_q[nxt_idx];
            div_rst_n_d = 1'b0;
            rst_cnt_d   = '0;
            state_d     = S_LOAD;
          end
        end

        default: begin
          state_d     = S_IDLE;
          div_rst_n_d = 1'b0;
        end
      endcase
    end
  end

  assign f_select    = f_select_q;
  assign div_reset_n = div_rst_n_q;
  assign busy        = busy_w;
  assign done        = done_q;
  assign cur_idx     = cur_idx_q;

endmodule
